// File: rtl/accum_cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, FSM states and the
// two's-complement overflow helper used by the ALU.
package accum_cpu_pkg;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_IN    = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LATCH   = 3'd2,
        S_DECODE  = 3'd3,
        S_EXEC    = 3'd4,
        S_WAIT_IN = 3'd5,
        S_HALTED  = 3'd6
    } state_t;

    // Subtraction is a + ~b + 1, so the effective operand sign is inverted.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic r_msb, input logic is_sub);
        logic b_eff;
        b_eff = is_sub ? ~b_msb : b_msb;
        return (a_msb == b_eff) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/accum_cpu_ram.sv
// Single-port program/data RAM: synchronous write, registered read (old data
// on a same-address write). Contents are deliberately not reset.
module accum_cpu_ram #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/accum_cpu_core.sv
// Accumulator CPU core: FSM controller, PC/IR/A registers, ALU and on-chip
// RAM. The host loads RAM while idle/halted, pulses start, and reads A.
module accum_cpu_core
    import accum_cpu_pkg::*;
#(
    parameter int DW = 8,   // must satisfy DW >= AW+3
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [DW-1:0] prog_data,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] a_out,
    output logic          aeq0,
    output logic          apos,
    output logic          ovf,
    output logic          busy,
    output logic          halted,
    output logic [AW-1:0] pc,
    output logic [2:0]    state_dbg
);

    // Input handshake: a word is taken on any cycle where in_valid && in_ready.
    // in_ready is registered and is high exactly while the FSM sits in WAIT_IN.

    state_t        state, state_next;
    logic [DW-1:0] acc;
    logic [DW-1:0] ir;
    logic [AW-1:0] pc_r;
    logic          ovf_r;
    logic          in_ready_r;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_q;

    logic [2:0]    opcode;
    logic [AW-1:0] ir_addr;
    logic          host_owns_ram;
    logic [DW-1:0] sum;
    logic [DW-1:0] diff;
    logic          branch_taken;

    assign opcode        = ir[DW-1 -: 3];
    assign ir_addr       = ir[AW-1:0];
    assign host_owns_ram = (state == S_IDLE) || (state == S_HALTED);
    assign sum           = acc + ram_q;
    assign diff          = acc - ram_q;
    assign branch_taken  = ((opcode == OP_JZ)   && (acc == '0)) ||
                           ((opcode == OP_JPOS) && !acc[DW-1]);

    accum_cpu_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH:  state_next = S_LATCH;
            S_LATCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_ADD, OP_SUB: state_next = S_EXEC;
                    OP_IN:                   state_next = S_WAIT_IN;
                    OP_HALT:                 state_next = S_HALTED;
                    default:                 state_next = S_FETCH;
                endcase
            end
            S_EXEC:   state_next = S_FETCH;
            S_WAIT_IN: begin
                if (in_valid) begin
                    state_next = S_FETCH;
                end
            end
            default:  state_next = S_IDLE;
        endcase
    end

    // RAM port mux: host when idle/halted, PC on fetch, IR operand otherwise
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = ir_addr;
        ram_wdata = acc;
        case (state)
            S_IDLE, S_HALTED: begin
                ram_we    = prog_we;
                ram_addr  = prog_addr;
                ram_wdata = prog_data;
            end
            S_FETCH: begin
                ram_addr = pc_r;
            end
            S_DECODE: begin
                ram_we = (opcode == OP_STORE);
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            ir         <= '0;
            pc_r       <= '0;
            ovf_r      <= 1'b0;
            in_ready_r <= 1'b0;
        end else begin
            in_ready_r <= (state_next == S_WAIT_IN);
            case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        pc_r  <= '0;
                        acc   <= '0;
                        ovf_r <= 1'b0;
                    end
                end
                S_LATCH: begin
                    ir   <= ram_q;
                    pc_r <= pc_r + 1'b1;
                end
                S_DECODE: begin
                    if (branch_taken) begin
                        pc_r <= ir_addr;
                    end
                end
                S_EXEC: begin
                    case (opcode)
                        OP_LOAD: acc <= ram_q;
                        OP_ADD: begin
                            acc   <= sum;
                            ovf_r <= ovf_r | signed_ovf(acc[DW-1], ram_q[DW-1], sum[DW-1], 1'b0);
                        end
                        OP_SUB: begin
                            acc   <= diff;
                            ovf_r <= ovf_r | signed_ovf(acc[DW-1], ram_q[DW-1], diff[DW-1], 1'b1);
                        end
                        default: begin
                        end
                    endcase
                end
                S_WAIT_IN: begin
                    if (in_valid) begin
                        acc <= in_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign a_out     = acc;
    assign aeq0      = (acc == '0);
    assign apos      = ~acc[DW-1];
    assign ovf       = ovf_r;
    assign busy      = !host_owns_ram;
    assign halted    = (state == S_HALTED);
    assign pc        = pc_r;
    assign state_dbg = state;

endmodule

// File: tb/tb_accum_cpu_core.sv
// Directed bench for accum_cpu_core (DW=8, AW=5) with hand-computed results.
module tb_accum_cpu_core;
    import accum_cpu_pkg::*;

    localparam int DW = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [DW-1:0] prog_data;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a_out;
    logic          aeq0;
    logic          apos;
    logic          ovf;
    logic          busy;
    logic          halted;
    logic [AW-1:0] pc;
    logic [2:0]    state_dbg;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    accum_cpu_core #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_out     (a_out),
        .aeq0      (aeq0),
        .apos      (apos),
        .ovf       (ovf),
        .busy      (busy),
        .halted    (halted),
        .pc        (pc),
        .state_dbg (state_dbg)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [DW-1:0] enc(input logic [2:0] op, input logic [AW-1:0] a);
        logic [DW-1:0] w;
        w = '0;
        w[DW-1 -: 3] = op;
        w[AW-1:0] = a;
        return w;
    endfunction

    // Driver tasks: inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halted(input string tag, output int cycles);
        cycles = 0;
        while (!halted && cycles < 200) begin
            tick();
            cycles++;
        end
        if (!halted) check({tag, "_timeout"}, 32'd0, 32'd1);
        if (exp_q.size() > 0) check({tag, "_a"}, a_out, exp_q.pop_front());
    endtask

    task automatic feed_in(input string tag, input logic [DW-1:0] d);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check({tag, "_in_timeout"}, 32'd0, 32'd1);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic read_mem(input logic [AW-1:0] a, output logic [DW-1:0] d);
        int n;
        mem_write(5'd0, enc(OP_LOAD, a));
        mem_write(5'd1, enc(OP_HALT, 5'd0));
        pulse_start();
        wait_halted("rd", n);
        d = a_out;
    endtask

    task automatic load_arith_prog(input logic [2:0] op, input logic [DW-1:0] m30,
                                   input logic [DW-1:0] m31);
        mem_write(5'd0, enc(OP_LOAD, 5'd30));
        mem_write(5'd1, enc(op, 5'd31));
        mem_write(5'd2, enc(OP_STORE, 5'd29));
        mem_write(5'd3, enc(OP_HALT, 5'd0));
        mem_write(5'd30, m30);
        mem_write(5'd31, m31);
    endtask

    task automatic load_branch_prog(input logic [2:0] br);
        mem_write(5'd0, enc(OP_IN, 5'd0));
        mem_write(5'd1, enc(br, 5'd4));
        mem_write(5'd2, enc(OP_LOAD, 5'd30));
        mem_write(5'd3, enc(OP_HALT, 5'd0));
        mem_write(5'd4, enc(OP_HALT, 5'd0));
        mem_write(5'd30, 8'h33);
    endtask

    initial begin
        int n;
        int held;
        logic [DW-1:0] d;

        rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0;
        prog_data = '0; in_data = '0; in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        check("rst_a", a_out, 8'h00);
        check("rst_pc", pc, 5'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_aeq0", aeq0, 1'b1);
        check("rst_apos", apos, 1'b1);

        // 5 + 7 -> 12, stored to M29
        load_arith_prog(OP_ADD, 8'd5, 8'd7);
        pulse_start();
        check("t1_busy", busy, 1'b1);
        exp_q.push_back(8'd12);
        wait_halted("t1", n);
        check("t1_cycles", n, 14);
        check("t1_pc", pc, 5'd4);
        check("t1_ovf", ovf, 1'b0);
        check("t1_busy_done", busy, 1'b0);
        read_mem(5'd29, d);
        check("t1_m29", d, 8'd12);

        // 0x70 + 0x20 overflows to 0x90
        load_arith_prog(OP_ADD, 8'h70, 8'h20);
        pulse_start();
        exp_q.push_back(8'h90);
        wait_halted("ovf", n);
        check("ovf_flag", ovf, 1'b1);
        check("ovf_apos", apos, 1'b0);
        mem_write(5'd31, 8'h01);
        pulse_start();
        check("ovf_cleared", ovf, 1'b0);
        exp_q.push_back(8'h71);
        wait_halted("ovf2", n);
        check("ovf2_flag", ovf, 1'b0);

        // 0x80 - 0x01 -> 0x7F overflows; 5 - 5 -> 0
        load_arith_prog(OP_SUB, 8'h80, 8'h01);
        pulse_start();
        exp_q.push_back(8'h7F);
        wait_halted("sub", n);
        check("sub_ovf", ovf, 1'b1);
        check("sub_apos", apos, 1'b1);
        load_arith_prog(OP_SUB, 8'd5, 8'd5);
        pulse_start();
        exp_q.push_back(8'h00);
        wait_halted("sub0", n);
        check("sub0_aeq0", aeq0, 1'b1);
        check("sub0_ovf", ovf, 1'b0);

        // JZ taken / not taken
        load_branch_prog(OP_JZ);
        pulse_start();
        feed_in("jz0", 8'h00);
        exp_q.push_back(8'h00);
        wait_halted("jz0", n);
        check("jz0_pc", pc, 5'd5);
        pulse_start();
        feed_in("jz3", 8'h03);
        exp_q.push_back(8'h33);
        wait_halted("jz3", n);
        check("jz3_pc", pc, 5'd4);

        // JPOS not taken on negative, taken on positive
        mem_write(5'd1, enc(OP_JPOS, 5'd4));
        pulse_start();
        feed_in("jpn", 8'h80);
        exp_q.push_back(8'h33);
        wait_halted("jpn", n);
        check("jpn_pc", pc, 5'd4);
        pulse_start();
        feed_in("jpp", 8'h05);
        exp_q.push_back(8'h05);
        wait_halted("jpp", n);
        check("jpp_pc", pc, 5'd5);

        // Handshake stall for 10 cycles
        mem_write(5'd1, enc(OP_JZ, 5'd4));
        pulse_start();
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        held = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (in_ready && pc == 5'd1 && a_out == 8'h00) held++;
        end
        check("hs_hold", held, 10);
        in_data  = 8'hA5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("hs_a", a_out, 8'hA5);
        check("hs_ready_drop", in_ready, 1'b0);
        exp_q.push_back(8'h33);
        wait_halted("hs", n);
        check("hs_pc", pc, 5'd4);

        // prog_we and start while busy are ignored
        pulse_start();
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        mem_write(5'd30, 8'hEE);
        pulse_start();
        check("busy_start_state", state_dbg, 3'd5);
        check("busy_start_pc", pc, 5'd1);
        feed_in("busy", 8'h03);
        exp_q.push_back(8'h33);
        wait_halted("busy", n);

        // Reset during EXEC of ADD
        load_arith_prog(OP_ADD, 8'd5, 8'd7);
        pulse_start();
        n = 0;
        while (!(state_dbg == 3'd4 && pc == 5'd2) && n < 50) begin
            tick();
            n++;
        end
        check("mid_found", (state_dbg == 3'd4 && pc == 5'd2), 1'b1);
        check("mid_a_pre", a_out, 8'd5);
        rst = 1'b1;
        tick();
        check("mid_a", a_out, 8'h00);
        check("mid_pc", pc, 5'd0);
        check("mid_busy", busy, 1'b0);
        check("mid_halted", halted, 1'b0);
        check("mid_in_ready", in_ready, 1'b0);
        check("mid_ovf", ovf, 1'b0);
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/accum_cpu_core.md
Name: accum_cpu_core

Overview:
- Parametrised successor to the fixed 8-bit accumulator datapath: one block holding the datapath, its FSM controller and on-chip program/data RAM.
- Widths and memory depth are generics.
- Adds a program-load port, start/halt control, a valid/ready input handshake and a sticky signed-overflow flag.
- Sits at the top of the processor subsystem; the host loads a program, pulses start, and reads results from A when halted.

Parameters:
- DW, 8, data/instruction word width; must satisfy DW >= AW+3.
- AW, 5, address width; RAM depth 2^AW, PC width AW.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; honoured only in IDLE or HALTED.
- prog_we  in  1  program/data RAM write strobe; honoured only in IDLE or HALTED.
- prog_addr  in  AW  RAM write address for the program port.
- prog_data  in  DW  RAM write data for the program port.
- in_data  in  DW  operand for the IN instruction.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  core is waiting on IN; a transfer happens when in_valid && in_ready.
- a_out  out  DW  accumulator A.
- aeq0  out  1  A == 0.
- apos  out  1  ~A[DW-1].
- ovf  out  1  sticky signed overflow from ADD/SUB.
- busy  out  1  FSM is in neither IDLE nor HALTED.
- halted  out  1  FSM is in HALTED.
- pc  out  AW  program counter.

Behaviour:
- Instruction format: opcode = word[DW-1:DW-3], operand address = word[AW-1:0]; bits in between are ignored.
- Opcodes:
  - 000 LOAD: A <= M[a].
  - 001 STORE: M[a] <= A.
  - 010 ADD: A <= A + M[a].
  - 011 SUB: A <= A - M[a].
  - 100 IN: A <= in_data, via handshake.
  - 101 JZ: if A == 0 then PC <= a.
  - 110 JPOS: if A[DW-1] == 0 then PC <= a.
  - 111 HALT.
- Reset values: A=0, PC=0, IR=0, ovf=0, state=IDLE, in_ready=0, busy=0, halted=0. RAM contents are not reset.
- RAM: synchronous write; read data is registered, so it is valid one cycle after the address is driven.
- RAM address mux:
  - IDLE/HALTED: prog_addr.
  - FETCH: PC.
  - DECODE/EXEC: IR[AW-1:0].
- FSM states: IDLE, FETCH, LATCH, DECODE, EXEC, WAIT_IN, HALTED.
- IDLE/HALTED + start: PC<=0, A<=0, ovf<=0, go to FETCH. start is ignored in all other states. If prog_we and start arrive together, the write is performed and the FSM still starts.
- FETCH: drive RAM address = PC; go to LATCH.
- LATCH: IR <= ram_q; PC <= PC+1 (wraps mod 2^AW); go to DECODE.
- DECODE, by opcode:
  - LOAD/ADD/SUB: go to EXEC.
  - STORE: write A to M[IR.a] this cycle; go to FETCH.
  - JZ/JPOS: PC updated if the condition holds, using A as it is in this cycle; go to FETCH.
  - IN: go to WAIT_IN.
  - HALT: go to HALTED.
- EXEC: A <= f(ram_q). On ADD/SUB, set ovf if the operand signs and result sign indicate two's-complement overflow. ovf is never cleared except by start or Reset. Go to FETCH.
- WAIT_IN: in_ready=1 (registered, high for exactly the WAIT_IN cycles). On in_valid, A <= in_data and go to FETCH. Otherwise stall indefinitely.
- Cycle counts from FETCH entry to the next FETCH: LOAD/ADD/SUB 4; STORE/JZ/JPOS 3; IN 3 + wait cycles; HALT enters HALTED after 3 cycles.
- Arithmetic is modulo 2^DW; carry is discarded.
- prog_we while busy is ignored; RAM is not written.
- Reset asserted mid-instruction returns the core immediately to reset values; an in-progress STORE is not performed.
- A program that runs off the end of memory wraps PC to 0.

Decomposition:
- Package accum_cpu_pkg:
  - opcode localparams OP_LOAD..OP_HALT (3 bits);
  - state enum/encoding for the FSM;
  - function for signed-overflow detection.
- One sub-module: accum_cpu_ram (parameters DW, AW) — single-port synchronous RAM with registered read, write port muxed outside.
- FSM, PC, IR, A and the ALU live in the top module.

Test Plan (DW=8, AW=5):
- Reset mid-run (during EXEC of ADD) -> next cycle A=0, PC=0, busy=0, halted=0, in_ready=0, ovf=0.
- Load M0=LOAD 30, M1=ADD 31, M2=STORE 29, M3=HALT; M30=5, M31=7; pulse start -> halted=1 after 4+4+3+3=14 cycles, a_out=12, M29=12, pc=4.
- Overflow: M30=0x70, M31=0x20, same program -> a_out=0x90, ovf=1, apos=0. Restart with M31=0x01 -> ovf cleared to 0 by start, final a_out=0x71.
- Branch: M0=IN, M1=JZ 4, M2=LOAD 30, M3=HALT, M4=HALT:
  - in_data=0 -> halts with pc=5;
  - in_data=3 -> pc=4, a_out=M30.
- Handshake: hold in_valid=0 for 10 cycles during WAIT_IN -> in_ready stays 1, pc and A unchanged; raise in_valid with in_data=0xA5 -> A=0xA5, in_ready drops next cycle.
- Program port: prog_we pulsed while busy -> RAM contents unchanged (read back after HALT via LOAD). start pulsed while busy -> ignored.
